mem_arbiter: RTL

- Shares the single external memory port between the CPU control unit and a debug/boot-loader port.
- Each requester gets a registered request/acknowledge handshake.
- Memory wait states are absorbed by a `mem_ready` input. A timeout counter converts a hung access into an error response, which the CPU side can raise as an access fault.
- Sits between the control/ALU address path and the memory device.

---
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory port between the CPU control unit
// and a debug/boot-loader port. Round-robin on ties, registered handshakes,
// and a wait-state timeout that turns a hung access into an error pulse.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 15,  // 1..255 ready-low cycles tolerated
    parameter int unsigned CNT_W   = 8    // must be wide enough to hold TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,      // synchronous, active-low

    input  logic        cpu_req,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_size,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_err,

    input  logic        dbg_req,
    input  logic        dbg_write,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    input  logic [3:0]  dbg_size,
    output logic [31:0] dbg_rdata,
    output logic        dbg_ack,
    output logic        dbg_err,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_size,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_RESP} state_e;
    typedef enum logic       {OWN_CPU, OWN_DBG}          owner_e;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    owner_e      last_q,  last_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic [3:0]  size_q,  size_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        err_q,   err_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] dbg_rdata_q, dbg_rdata_d;

    logic grant_cpu;
    logic grant_dbg;

    // Round-robin grant: a lone request wins; on a tie the requester that
    // was not granted last wins (last_q resets to DBG so CPU wins first).
    assign grant_cpu = cpu_req && (!dbg_req || (last_q == OWN_DBG));
    assign grant_dbg = dbg_req && !grant_cpu;

    // Next-state logic: grant and latch in IDLE, wait/timeout in XFER,
    // single response cycle in RESP.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement leaves one unassigned, which would infer a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        size_d      = size_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_cpu) begin
                    owner_d = OWN_CPU;
                    last_d  = OWN_CPU;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    write_d = cpu_write;
                    size_d  = cpu_size;
                    cnt_d   = '0;
                    state_d = ST_XFER;
                end else if (grant_dbg) begin
                    owner_d = OWN_DBG;
                    last_d  = OWN_DBG;
                    addr_d  = dbg_addr;
                    wdata_d = dbg_wdata;
                    write_d = dbg_write;
                    size_d  = dbg_size;
                    cnt_d   = '0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (mem_ready) begin
                    // Stores leave the owner's read-data register untouched.
                    if (!write_q) begin
                        if (owner_q == OWN_CPU) cpu_rdata_d = mem_rdata;
                        else                    dbg_rdata_d = mem_rdata;
                    end
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == TIMEOUT_C) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                // Requests seen here are ignored so a requester still holding
                // req in its ack cycle is not granted twice.
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous active-low reset; reset wins in any
    // state, including an access still in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (!reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_CPU;
            last_q      <= OWN_DBG;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            size_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            size_q      <= size_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // Outputs decode only registered state, so strobes and pulses are
    // glitch-free and read/write can never be high together.
    logic in_xfer;
    logic in_resp;
    assign in_xfer = (state_q == ST_XFER);
    assign in_resp = (state_q == ST_RESP);

    assign mem_addr  = in_xfer ? addr_q : '0;
    assign mem_size  = in_xfer ? size_q : '0;
    assign mem_wdata = (in_xfer && write_q) ? wdata_q : '0;
    assign mem_read  = in_xfer && !write_q;
    assign mem_write = in_xfer &&  write_q;

    assign cpu_ack   = in_resp && (owner_q == OWN_CPU) && !err_q;
    assign cpu_err   = in_resp && (owner_q == OWN_CPU) &&  err_q;
    assign dbg_ack   = in_resp && (owner_q == OWN_DBG) && !err_q;
    assign dbg_err   = in_resp && (owner_q == OWN_DBG) &&  err_q;

    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule
